// File: rtl/dll_lock_sequencer_pkg.sv
// Shared state encodings and default timing values for the DLL lock sequencer.
package dll_lock_sequencer_pkg;

    // Sequencer states; the encoding is visible on seq_state for debug.
    typedef enum logic [1:0] {
        ST_RESET_DLL = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABILIZE = 2'd2,
        ST_RUN       = 2'd3
    } seq_state_e;

    // Default timing, in ui_board_clk cycles.
    localparam int DEF_DLL_RST_CYCLES = 8;      // CLKDLL needs at least 3
    localparam int DEF_LOCK_TIMEOUT   = 65536;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_CNT_W          = 17;

    // Lock-loss counter saturates instead of wrapping.
    localparam logic [7:0] LOST_CNT_MAX = 8'd255;

endpackage

// File: rtl/dll_lock_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a
// configurable reset value so an input can come up in its safe state.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; only sync_q is used downstream.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/dll_lock_sequencer.sv
// DLL lock sequencer: pulses the DLL reset, waits for both DLLs to report
// lock, requires a stable lock window, then releases the system reset.
// Any lock loss while running restarts the whole sequence.
module dll_lock_sequencer
    import dll_lock_sequencer_pkg::*;
#(
    parameter int DLL_RST_CYCLES = DEF_DLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic       ui_board_clk,
    input  logic       ui_reset,
    input  logic       ui_clk_mirror_locked_int,
    input  logic       ui_clk_mirror_locked_ext,
    output logic       dll_rst,
    output logic       sys_rst,
    output logic       clocks_ready,
    output logic [7:0] lock_lost_count,
    output logic [1:0] seq_state
);

    // Terminal counts: each state ends on the cycle its counter shows N-1.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(DLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    logic lock_int_n_sync;
    logic lock_ext_n_sync;
    logic both_locked;

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       lost_q, lost_d;
    logic             dll_rst_q, dll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;

    // Lock pins are active-low; synchronizers reset to 1 = "not locked".
    sync_2ff #(.RESET_VAL(1'b1)) u_sync_int (
        .clk_i (ui_board_clk),
        .rst_i (ui_reset),
        .d_i   (ui_clk_mirror_locked_int),
        .q_o   (lock_int_n_sync)
    );

    sync_2ff #(.RESET_VAL(1'b1)) u_sync_ext (
        .clk_i (ui_board_clk),
        .rst_i (ui_reset),
        .d_i   (ui_clk_mirror_locked_ext),
        .q_o   (lock_ext_n_sync)
    );

    assign both_locked = ~lock_int_n_sync & ~lock_ext_n_sync;

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d = state_q;
        lost_d  = lost_q;

        case (state_q)
            ST_RESET_DLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                // A timeout re-pulses the DLL but is not a lock loss.
                if (both_locked) begin
                    state_d = ST_STABILIZE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_RESET_DLL;
                end
            end
            ST_STABILIZE: begin
                // Loss is checked first so it wins over window completion.
                if (!both_locked) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!both_locked) begin
                    state_d = ST_RESET_DLL;
                    if (lost_q != LOST_CNT_MAX) begin
                        lost_d = lost_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_RESET_DLL;
        endcase

        // Counter restarts on every transition and idles while running.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == ST_RUN) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Outputs decoded from the next state so they line up with state_q.
        dll_rst_d = (state_d == ST_RESET_DLL);
        sys_rst_d = (state_d != ST_RUN);
        ready_d   = (state_d == ST_RUN);
    end

    // State, counter and output registers; reset forces the safe values.
    always_ff @(posedge ui_board_clk or posedge ui_reset) begin
        if (ui_reset) begin
            state_q   <= ST_RESET_DLL;
            cnt_q     <= '0;
            lost_q    <= 8'd0;
            dll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lost_q    <= lost_d;
            dll_rst_q <= dll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
        end
    end

    assign dll_rst         = dll_rst_q;
    assign sys_rst         = sys_rst_q;
    assign clocks_ready    = ready_q;
    assign lock_lost_count = lost_q;
    assign seq_state       = state_q;

endmodule

// File: tb/tb_dll_lock_sequencer.sv
// Directed testbench for dll_lock_sequencer with short timing parameters
// (DLL reset 4, lock timeout 64, stable window 16).
module tb_dll_lock_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lint = 1'b1;
    logic       lext = 1'b1;
    logic       dll_rst;
    logic       sys_rst;
    logic       cr;
    logic [7:0] llc;
    logic [1:0] st;

    int vn  = 0;
    int err = 0;

    dll_lock_sequencer #(
        .DLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (64),
        .STABLE_CYCLES  (16),
        .CNT_W          (17)
    ) dut (
        .ui_board_clk             (clk),
        .ui_reset                 (rst),
        .ui_clk_mirror_locked_int (lint),
        .ui_clk_mirror_locked_ext (lext),
        .dll_rst                  (dll_rst),
        .sys_rst                  (sys_rst),
        .clocks_ready             (cr),
        .lock_lost_count          (llc),
        .seq_state                (st)
    );

    always #5 clk = ~clk;

    // Global time bound.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vn);
        $fatal(1, "watchdog");
    end

    // All stimulus and sampling happens on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Steps until seq_state equals tgt, at most budget cycles.
    task automatic wait_state(input logic [1:0] tgt, input int budget, output bit ok);
        int i;
        ok = 1'b0;
        i  = 0;
        while (!ok && i < budget) begin
            step(1);
            if (st == tgt) ok = 1'b1;
            i++;
        end
    endtask

    // Reset pulse with the given lock pin levels; returns just after release,
    // so step(k) afterwards observes the state after the k-th rising edge.
    task automatic apply_reset(input logic li, input logic le);
        @(negedge clk);
        rst  = 1'b1;
        lint = li;
        lext = le;
        step(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst  = 1'b1;
        lint = 1'b1;
        lext = 1'b1;
        step(1);
        vn++;
        if ({st, dll_rst, sys_rst, cr, llc} !== {2'd0, 1'b1, 1'b1, 1'b0, 8'd0}) begin
            err++;
            $display("FAIL reset_state: st=%0d dll_rst=%0b sys_rst=%0b ready=%0b lost=%0d, need 0 1 1 0 0",
                     st, dll_rst, sys_rst, cr, llc);
        end
        $display("test_reset done");
    endtask

    task automatic test_lock_up();
        apply_reset(1'b0, 1'b0);
        step(3);
        vn++;
        if (st !== 2'd0 || dll_rst !== 1'b1) begin
            err++;
            $display("FAIL lockup_dllrst_c3: st=%0d dll_rst=%0b, need 0 1", st, dll_rst);
        end
        step(1);
        vn++;
        if (st !== 2'd1 || dll_rst !== 1'b0) begin
            err++;
            $display("FAIL lockup_wait_c4: st=%0d dll_rst=%0b, need 1 0", st, dll_rst);
        end
        step(1);
        vn++;
        if (st !== 2'd2) begin
            err++;
            $display("FAIL lockup_stab_c5: st=%0d, need 2", st);
        end
        step(15);
        vn++;
        if (st !== 2'd2 || sys_rst !== 1'b1 || cr !== 1'b0) begin
            err++;
            $display("FAIL lockup_stab_c20: st=%0d sys_rst=%0b ready=%0b, need 2 1 0", st, sys_rst, cr);
        end
        step(1);
        vn++;
        if (st !== 2'd3 || sys_rst !== 1'b0 || cr !== 1'b1 || dll_rst !== 1'b0) begin
            err++;
            $display("FAIL lockup_run_c21: st=%0d sys_rst=%0b ready=%0b dll_rst=%0b, need 3 0 1 0",
                     st, sys_rst, cr, dll_rst);
        end
        $display("test_lock_up done");
    endtask

    // One-cycle int-lock glitch while running.
    task automatic test_glitch();
        lint = 1'b1;
        step(1);
        lint = 1'b0;
        step(1);
        vn++;
        if (st !== 2'd3) begin
            err++;
            $display("FAIL glitch_early: st=%0d at 2 cycles, need 3", st);
        end
        step(1);
        vn++;
        if ({st, dll_rst, sys_rst, cr, llc} !== {2'd0, 1'b1, 1'b1, 1'b0, 8'd1}) begin
            err++;
            $display("FAIL glitch_c3: st=%0d dll_rst=%0b sys_rst=%0b ready=%0b lost=%0d, need 0 1 1 0 1",
                     st, dll_rst, sys_rst, cr, llc);
        end
        step(20);
        vn++;
        if (st !== 2'd2) begin
            err++;
            $display("FAIL glitch_reseq_c20: st=%0d, need 2", st);
        end
        step(1);
        vn++;
        if (st !== 2'd3 || cr !== 1'b1 || llc !== 8'd1) begin
            err++;
            $display("FAIL glitch_reseq_run: st=%0d ready=%0b lost=%0d, need 3 1 1", st, cr, llc);
        end
        $display("test_glitch done");
    endtask

    // Lock loss on the last cycle of the stable window.
    task automatic test_stab_drop();
        bit ok;
        apply_reset(1'b0, 1'b0);
        step(18);
        lext = 1'b1;
        step(2);
        vn++;
        if (st !== 2'd2) begin
            err++;
            $display("FAIL stabdrop_c20: st=%0d, need 2", st);
        end
        step(1);
        vn++;
        if (st !== 2'd1 || cr !== 1'b0 || sys_rst !== 1'b1 || llc !== 8'd0) begin
            err++;
            $display("FAIL stabdrop_c21: st=%0d ready=%0b sys_rst=%0b lost=%0d, need 1 0 1 0",
                     st, cr, sys_rst, llc);
        end
        lext = 1'b0;
        wait_state(2'd3, 40, ok);
        vn++;
        if (!ok || llc !== 8'd0) begin
            err++;
            $display("FAIL stabdrop_recover: reached_run=%0b lost=%0d, need 1 0", ok, llc);
        end
        $display("test_stab_drop done");
    endtask

    // Ext lock never asserts: periodic DLL reset, never ready.
    task automatic test_timeout();
        int  bad;
        logic exp_rst;
        apply_reset(1'b0, 1'b1);
        bad = 0;
        for (int k = 1; k <= 3 * 68 + 4; k++) begin
            step(1);
            exp_rst = ((k % 68) < 4);
            vn++;
            if (dll_rst !== exp_rst || st !== (exp_rst ? 2'd0 : 2'd1) || cr !== 1'b0 || llc !== 8'd0) begin
                err++;
                bad++;
                if (bad <= 5)
                    $display("FAIL timeout_c%0d: dll_rst=%0b st=%0d ready=%0b lost=%0d, need %0b %0d 0 0",
                             k, dll_rst, st, cr, llc, exp_rst, exp_rst ? 0 : 1);
            end
        end
        $display("test_timeout done");
    endtask

    // 300 losses saturate the counter; then reset mid-STABILIZE and restart.
    task automatic test_saturate();
        bit   ok;
        bit   ok2;
        int   bad;
        logic [7:0] exp_lost;
        apply_reset(1'b0, 1'b0);
        wait_state(2'd3, 40, ok);
        vn++;
        if (!ok) begin
            err++;
            $display("FAIL sat_initial_run: st=%0d, need 3", st);
        end
        bad = 0;
        for (int i = 1; i <= 300; i++) begin
            lint = 1'b1;
            step(1);
            lint = 1'b0;
            wait_state(2'd0, 5, ok);
            exp_lost = (i > 255) ? 8'd255 : 8'(i);
            vn++;
            if (!ok || llc !== exp_lost) begin
                err++;
                bad++;
                if (bad <= 5)
                    $display("FAIL sat_loss_%0d: saw_reset=%0b lost=%0d, need 1 %0d", i, ok, llc, exp_lost);
            end
            wait_state(2'd3, 40, ok2);
            vn++;
            if (!ok2) begin
                err++;
                $display("FAIL sat_rerun_%0d: st=%0d, need 3", i, st);
            end
        end
        vn++;
        if (llc !== 8'd255) begin
            err++;
            $display("FAIL sat_final: lost=%0d, need 255", llc);
        end
        lint = 1'b1;
        step(1);
        lint = 1'b0;
        wait_state(2'd2, 40, ok);
        step(5);
        #1;
        rst = 1'b1;
        #1;
        vn++;
        if (!ok || {st, dll_rst, sys_rst, cr, llc} !== {2'd0, 1'b1, 1'b1, 1'b0, 8'd0}) begin
            err++;
            $display("FAIL async_reset: st=%0d dll_rst=%0b sys_rst=%0b ready=%0b lost=%0d, need 0 1 1 0 0",
                     st, dll_rst, sys_rst, cr, llc);
        end
        @(negedge clk);
        rst = 1'b0;
        step(3);
        vn++;
        if (st !== 2'd0 || dll_rst !== 1'b1) begin
            err++;
            $display("FAIL restart_c3: st=%0d dll_rst=%0b, need 0 1", st, dll_rst);
        end
        step(1);
        vn++;
        if (st !== 2'd1 || dll_rst !== 1'b0) begin
            err++;
            $display("FAIL restart_c4: st=%0d dll_rst=%0b, need 1 0", st, dll_rst);
        end
        $display("test_saturate done");
    endtask

    initial begin
        test_reset();
        test_lock_up();
        test_glitch();
        test_stab_drop();
        test_timeout();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vn, err);
        $finish;
    end

endmodule
